// File: rtl/load_data_unit.sv
// load_data_unit
// Performs one memory load per accepted start: checks alignment/size, issues a
// word-aligned read, waits for the read strobe (bounded by MAX_WAIT cycles),
// then extracts and sign/zero-extends the addressed byte/halfword/word.
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   i_start        load request, sampled only in IDLE
//   i_addr         byte address of the load
//   i_size         00 word, 01 halfword, 10 byte, 11 illegal
//   i_unsigned_ld  1 = zero-extend, 0 = sign-extend (byte/halfword)
//   i_mem_rdata    memory read word
//   i_mem_ready    memory read-data-valid strobe
//   o_mem_addr     word-aligned memory address, stable during REQ
//   o_mem_rd       memory read request, high exactly while in REQ
//   o_busy         high whenever not in IDLE
//   o_done         one-cycle completion pulse
//   o_err          misalignment, illegal size or timeout; valid with o_done
//   o_load_data    extended load result
module load_data_unit #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned_ld,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_rd,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_load_data
);

   localparam int unsigned WaitW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   // Last REQ cycle: a miss here means the counter reaches MAX_WAIT -> timeout.
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_t;

   state_t            r_state;
   logic [WaitW-1:0]  r_wait;
   logic [1:0]        r_offset;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [31:0]       r_mem_addr;
   logic              r_mem_rd;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [31:0]       r_load_data;

   logic              w_illegal;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_extended;

   always_comb begin
      unique case (i_size)
         2'b00:   w_illegal = (i_addr[1:0] != 2'b00);
         2'b01:   w_illegal = i_addr[0];
         2'b10:   w_illegal = 1'b0;
         default: w_illegal = 1'b1;
      endcase
   end

   // Little-endian lane select from the latched offset.
   always_comb begin
      w_byte     = i_mem_rdata[8*r_offset +: 8];
      w_half     = r_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      w_extended = i_mem_rdata;
      case (r_size)
         2'b01:   w_extended = r_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
         2'b10:   w_extended = r_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
         default: w_extended = i_mem_rdata;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_wait      <= '0;
         r_offset    <= 2'b00;
         r_size      <= 2'b00;
         r_unsigned  <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_rd    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_load_data <= 32'h0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_offset    <= i_addr[1:0];
                  r_size      <= i_size;
                  r_unsigned  <= i_unsigned_ld;
                  r_wait      <= '0;
                  r_busy      <= 1'b1;
                  r_load_data <= 32'h0;
                  if (w_illegal) begin
                     // Reject without touching memory.
                     r_state <= StDone;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= StReq;
                     r_mem_addr <= {i_addr[31:2], 2'b00};
                     r_mem_rd   <= 1'b1;
                     r_err      <= 1'b0;
                  end
               end
            end
            StReq: begin
               if (i_mem_ready) begin
                  // Data wins over a simultaneous timeout.
                  r_state     <= StDone;
                  r_mem_rd    <= 1'b0;
                  r_done      <= 1'b1;
                  r_err       <= 1'b0;
                  r_load_data <= w_extended;
               end else begin
                  r_wait <= r_wait + WaitW'(1);
                  if (r_wait == WaitLast) begin
                     r_state     <= StDone;
                     r_mem_rd    <= 1'b0;
                     r_done      <= 1'b1;
                     r_err       <= 1'b1;
                     r_load_data <= 32'h0;
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= StIdle;
               r_mem_rd <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign o_mem_addr  = r_mem_addr;
   assign o_mem_rd    = r_mem_rd;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_load_data = r_load_data;

endmodule
